// File: rtl/event_counter_bank.sv
// Bank of programmable event counters with per-counter source select, level/edge
// counting, sticky wrap flag and maskable overflow interrupt behind a word-addressed register port.
module event_counter_bank #(
   parameter int N_EVENTS   = 10,
   parameter int N_COUNTERS = 4,
   parameter int CNT_W      = 64,
   parameter int SEL_W      = $clog2(N_EVENTS + 2),
   parameter int ADDR_W     = $clog2(N_COUNTERS) + 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_EVENTS-1:0] events,
   input  logic                freeze,
   input  logic                csr_we,
   input  logic                csr_re,
   input  logic [ADDR_W-1:0]   csr_addr,
   input  logic [31:0]         csr_wdata,
   output logic [31:0]         csr_rdata,
   output logic                csr_rvalid,
   output logic                ovf_irq
);

   localparam logic [SEL_W-1:0] SEL_CYCLE = '1;

   logic [CNT_W-1:0]      cnt_q [N_COUNTERS];
   logic [CNT_W-1:0]      cnt_d [N_COUNTERS];
   logic [SEL_W-1:0]      sel_q [N_COUNTERS];
   logic [SEL_W-1:0]      sel_d [N_COUNTERS];
   logic [N_COUNTERS-1:0] edge_q, edge_d;
   logic [N_COUNTERS-1:0] irqen_q, irqen_d;
   logic [N_COUNTERS-1:0] ovf_q, ovf_d;
   logic [N_COUNTERS-1:0] inc;
   logic [N_EVENTS-1:0]   prev_q;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rvalid_q;
   logic                  irq_q;
   logic [1:0]            reg_sel;
   int                    idx;

   assign reg_sel = csr_addr[1:0];
   assign idx     = int'(csr_addr >> 2);

   // Edge mode only qualifies real event sources; the cycle source counts every cycle.
   function automatic logic src_hit(input logic [SEL_W-1:0]    sel,
                                    input logic                edge_mode,
                                    input logic [N_EVENTS-1:0] ev,
                                    input logic [N_EVENTS-1:0] pv);
      logic hit;
      hit = 1'b0;
      if (sel == SEL_CYCLE) begin
         hit = 1'b1;
      end else begin
         for (int e = 0; e < N_EVENTS; e++) begin
            if (int'(sel) == e + 1) hit = ev[e] & ~(edge_mode & pv[e]);
         end
      end
      return hit;
   endfunction

   always_comb begin
      for (int i = 0; i < N_COUNTERS; i++) begin
         inc[i] = ~freeze & src_hit(sel_q[i], edge_q[i], events, prev_q);
      end
   end

   always_comb begin
      rdata_d = '0;
      edge_d  = edge_q;
      irqen_d = irqen_q;
      ovf_d   = ovf_q;
      for (int i = 0; i < N_COUNTERS; i++) begin
         cnt_d[i] = cnt_q[i];
         sel_d[i] = sel_q[i];
         if (csr_re && idx == i) begin
            case (reg_sel)
               2'd0: rdata_d = cnt_q[i][31:0];
               2'd1: rdata_d = 32'(cnt_q[i][CNT_W-1:32]);
               2'd2: begin
                  rdata_d[SEL_W-1:0] = sel_q[i];
                  rdata_d[8]         = edge_q[i];
                  rdata_d[9]         = irqen_q[i];
               end
               default: rdata_d[0] = ovf_q[i];
            endcase
         end
         if (csr_we && idx == i && reg_sel == 2'd2) begin
            sel_d[i]   = csr_wdata[SEL_W-1:0];
            edge_d[i]  = csr_wdata[8];
            irqen_d[i] = csr_wdata[9];
         end
         if (csr_we && idx == i && reg_sel == 2'd3 && csr_wdata[0]) ovf_d[i] = 1'b0;
         // Count writes pre-empt the increment; a wrap overrides a same-cycle clear.
         if (csr_we && idx == i && reg_sel == 2'd0) begin
            cnt_d[i][31:0] = csr_wdata;
         end else if (csr_we && idx == i && reg_sel == 2'd1) begin
            cnt_d[i][CNT_W-1:32] = csr_wdata[CNT_W-33:0];
         end else if (inc[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (&cnt_q[i]) ovf_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_q[i] <= '0;
            sel_q[i] <= '0;
         end
         edge_q   <= '0;
         irqen_q  <= '0;
         ovf_q    <= '0;
         prev_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_q[i] <= cnt_d[i];
            sel_q[i] <= sel_d[i];
         end
         edge_q   <= edge_d;
         irqen_q  <= irqen_d;
         ovf_q    <= ovf_d;
         prev_q   <= events;
         rvalid_q <= csr_re;
         if (csr_re) rdata_q <= rdata_d;
         irq_q    <= |(ovf_q & irqen_q);
      end
   end

   assign csr_rdata  = rdata_q;
   assign csr_rvalid = rvalid_q;
   assign ovf_irq    = irq_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Bench for event_counter_bank: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the register/counter rules.
module tb_event_counter_bank;

   localparam int NE = 10;
   localparam int NC = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [NE-1:0] events;
   logic          freeze;
   logic          csr_we;
   logic          csr_re;
   logic [AW-1:0] csr_addr;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          csr_rvalid;
   logic          ovf_irq;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   event_counter_bank #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .events     (events),
      .freeze     (freeze),
      .csr_we     (csr_we),
      .csr_re     (csr_re),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .csr_rvalid (csr_rvalid),
      .ovf_irq    (ovf_irq)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [63:0] m_cnt  [NC];
   int          m_sel  [NC];
   bit          m_edge [NC];
   bit          m_ien  [NC];
   bit          m_ovf  [NC];
   logic [NE-1:0] m_prev;
   logic [31:0] m_rdata;
   bit          m_rvalid;
   bit          m_irq;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int   idx, r, s;
      bit   hit, wr, irq_next;
      logic [31:0] rd;
      idx = int'(csr_addr) / 4;
      r   = int'(csr_addr) % 4;
      if (!rst) begin
         for (int i = 0; i < NC; i++) begin
            m_cnt[i] = '0; m_sel[i] = 0; m_edge[i] = 0; m_ien[i] = 0; m_ovf[i] = 0;
         end
         m_prev = '0; m_rdata = '0; m_rvalid = 0; m_irq = 0;
         return;
      end
      irq_next = 0;
      for (int i = 0; i < NC; i++) irq_next = irq_next | (m_ovf[i] & m_ien[i]);
      if (csr_re) begin
         rd = '0;
         if (idx < NC) begin
            if (r == 0) rd = m_cnt[idx][31:0];
            else if (r == 1) rd = m_cnt[idx][63:32];
            else if (r == 2) rd = m_sel[idx] + (m_edge[idx] ? 256 : 0) + (m_ien[idx] ? 512 : 0);
            else rd = m_ovf[idx] ? 1 : 0;
         end
         m_rdata = rd;
      end
      m_rvalid = csr_re;
      for (int i = 0; i < NC; i++) begin
         s   = m_sel[i];
         hit = 0;
         if (s == 15) hit = 1;
         else if (s >= 1 && s <= NE) hit = m_edge[i] ? (events[s-1] && !m_prev[s-1]) : events[s-1];
         if (freeze) hit = 0;
         wr = csr_we && (idx == i);
         if (wr && r == 2) begin
            m_sel[i]  = int'(csr_wdata[3:0]);
            m_edge[i] = csr_wdata[8];
            m_ien[i]  = csr_wdata[9];
         end
         if (wr && r == 3 && csr_wdata[0]) m_ovf[i] = 0;
         if (wr && r == 0) m_cnt[i][31:0] = csr_wdata;
         else if (wr && r == 1) m_cnt[i][63:32] = csr_wdata;
         else if (hit) begin
            if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
               m_cnt[i] = '0;
               m_ovf[i] = 1;
            end else begin
               m_cnt[i] = m_cnt[i] + 64'd1;
            end
         end
      end
      m_prev = events;
      m_irq  = irq_next;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("rvalid_cycle", 64'(csr_rvalid), 64'(m_rvalid));
         check("rdata_cycle", 64'(csr_rdata), 64'(m_rdata));
         check("irq_cycle", 64'(ovf_irq), 64'(m_irq));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int c, input int r, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_addr  = AW'(c * 4 + r);
      csr_wdata = d;
      tick();
      csr_we    = 1'b0;
   endtask

   task automatic rd(input int c, input int r, output logic [31:0] d);
      csr_re   = 1'b1;
      csr_addr = AW'(c * 4 + r);
      tick();
      csr_re   = 1'b0;
      check("rvalid_pulse", 64'(csr_rvalid), 64'd1);
      d = csr_rdata;
   endtask

   task automatic rd_expect(input string name, input int c, input int r, input logic [31:0] exp);
      logic [31:0] d;
      rd(c, r, d);
      check(name, 64'(d), 64'(exp));
   endtask

   function automatic logic [31:0] rnd_data();
      int k;
      k = $urandom_range(0, 3);
      if (k == 0) return 32'hFFFF_FFFF;
      if (k == 1) return 32'hFFFF_FFF8;
      return $urandom;
   endfunction

   logic [6:0] pat;

   initial begin
      rst = 1'b0; events = '0; freeze = 1'b0;
      csr_we = 1'b0; csr_re = 1'b0; csr_addr = '0; csr_wdata = '0;
      tick(); tick();
      rst = 1'b1;
      chk_en = 1'b1;

      // Reset values
      for (int r = 0; r < 4; r++) rd_expect("reset_read", 0, r, 32'h0);
      check("reset_irq", 64'(ovf_irq), 64'd0);
      tick();
      check("rvalid_drops", 64'(csr_rvalid), 64'd0);

      // Level counting on load
      wr(1, 2, 32'h1);
      events[0] = 1'b1; repeat (5) tick();
      events[0] = 1'b0; repeat (3) tick();
      events[0] = 1'b1; repeat (2) tick();
      events[0] = 1'b0;
      rd_expect("level_count", 1, 0, 32'd7);
      rd_expect("level_count_hi", 1, 1, 32'd0);
      rd_expect("sel0_idle", 0, 0, 32'd0);
      rd_expect("config_read", 1, 2, 32'h1);

      // Edge counting on execute, then with freeze over the third rising edge
      wr(2, 2, 32'h10A);
      pat = 7'b1101011;
      for (int p = 0; p < 7; p++) begin events[9] = pat[p]; tick(); end
      events[9] = 1'b0; tick();
      rd_expect("edge_count", 2, 0, 32'd3);
      wr(2, 0, 32'h0);
      for (int p = 0; p < 7; p++) begin
         events[9] = pat[p];
         freeze    = (p >= 5);
         tick();
      end
      events[9] = 1'b0; freeze = 1'b0; tick();
      rd_expect("edge_freeze", 2, 0, 32'd2);
      rd_expect("edge_config", 2, 2, 32'h10A);

      // Wrap of the cycle counter with irq enabled
      freeze = 1'b1;
      wr(3, 2, 32'h20F);
      wr(3, 1, 32'hFFFF_FFFF);
      wr(3, 0, 32'hFFFF_FFFE);
      freeze = 1'b0;
      tick(); tick();
      freeze = 1'b1;
      check("irq_not_yet", 64'(ovf_irq), 64'd0);
      tick();
      check("irq_set", 64'(ovf_irq), 64'd1);
      rd_expect("wrap_lo", 3, 0, 32'd0);
      rd_expect("wrap_hi", 3, 1, 32'd0);
      rd_expect("wrap_ovf", 3, 3, 32'd1);
      wr(3, 3, 32'h1);
      check("irq_lags_clear", 64'(ovf_irq), 64'd1);
      tick();
      check("irq_cleared", 64'(ovf_irq), 64'd0);
      rd_expect("ovf_cleared", 3, 3, 32'd0);
      wr(3, 1, 32'hFFFF_FFFF);
      wr(3, 0, 32'hFFFF_FFFF);
      freeze = 1'b0;
      wr(3, 3, 32'h1);
      freeze = 1'b1;
      rd_expect("wrap_beats_clear", 3, 3, 32'd1);
      rd_expect("wrap2_lo", 3, 0, 32'd0);
      wr(3, 3, 32'h1);
      wr(3, 2, 32'h0);
      freeze = 1'b0;

      // Write beats same-cycle increment
      events[0] = 1'b1;
      wr(1, 0, 32'h100);
      events[0] = 1'b0;
      rd_expect("write_wins", 1, 0, 32'h100);
      events[0] = 1'b1; tick(); events[0] = 1'b0;
      rd_expect("after_write", 1, 0, 32'h101);

      // Out-of-range counter index
      wr(4, 0, 32'h1234);
      wr(7, 2, 32'h3FF);
      rd_expect("oor_read", 4, 0, 32'd0);
      rd_expect("oor_cfg", 7, 2, 32'd0);
      rd_expect("oor_no_alias", 0, 0, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 399) != 0);
         events    = NE'($urandom & $urandom);
         freeze    = ($urandom_range(0, 9) == 0);
         csr_we    = ($urandom_range(0, 3) == 0);
         csr_re    = ($urandom_range(0, 2) == 0);
         csr_addr  = AW'($urandom_range(0, 31));
         csr_wdata = rnd_data();
         tick();
      end
      rst = 1'b1; csr_we = 1'b0; csr_re = 1'b0; freeze = 1'b0;

      // Reset mid-count discards a pending read
      wr(1, 2, 32'h00F);
      wr(2, 2, 32'h001);
      events = '1;
      repeat (4) tick();
      rst = 1'b0; csr_re = 1'b1; csr_addr = AW'(1 * 4);
      tick();
      rst = 1'b1; csr_re = 1'b0; events = '0;
      check("rst_rvalid", 64'(csr_rvalid), 64'd0);
      check("rst_rdata", 64'(csr_rdata), 64'd0);
      for (int c = 0; c < NC; c++) begin
         rd_expect("rst_cnt_lo", c, 0, 32'd0);
         rd_expect("rst_cnt_hi", c, 1, 32'd0);
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/event_counter_bank.md
Name: event_counter_bank

Overview:
- Parametrised bank of N_COUNTERS programmable event counters fed by the core's packed event vector.
- Event vector bit order: load, store, unaligned, arithmetic, trap, interrupt, conditional_branch, unconditional_branch, branch, execute (bit 0 to bit 9).
- Each counter selects one event source (or every cycle), counts in level or rising-edge mode, and wraps with a sticky overflow flag and maskable interrupt.
- Sits beside the CSR unit and is accessed through a simple word-addressed register port.

Parameters:
- N_EVENTS, default 10: width of the event vector.
- N_COUNTERS, default 4: number of counters, range 1..16.
- CNT_W, default 64: counter width, range 33..64.
- SEL_W, default $clog2(N_EVENTS+2): width of the event-select field.
- ADDR_W, default $clog2(N_COUNTERS)+2: register address width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- events  input  N_EVENTS  event strobes, bit order as in Overview.
- freeze  input  1  global inhibit; while high, no counter increments.
- csr_we  input  1  register write strobe.
- csr_re  input  1  register read strobe.
- csr_addr  input  ADDR_W  bits [1:0] select the register, upper bits select the counter index.
- csr_wdata  input  32  write data.
- csr_rdata  output  32  read data, registered.
- csr_rvalid  output  1  high for one cycle when csr_rdata is valid.
- ovf_irq  output  1  overflow interrupt, level.

Behaviour:
- Reset (rst low at a clk edge) clears:
  - every counter, select, mode bit, irq-enable bit and sticky ovf flag;
  - the edge-history registers;
  - csr_rdata, csr_rvalid and ovf_irq (all 0).
- Register map per counter i (reg = csr_addr[1:0]):
  - reg 0: count[31:0].
  - reg 1: count[CNT_W-1:32], zero-extended on read.
  - reg 2: config.
    - [SEL_W-1:0] = sel.
    - bit 8 = edge mode.
    - bit 9 = irq enable.
    - Other bits read 0.
  - reg 3: status. Bit 0 = sticky ovf; writing 1 clears it, writing 0 has no effect.
- Index >= N_COUNTERS: writes are ignored and reads return 0.
- Source select:
  - sel 1..N_EVENTS selects events[sel-1].
  - sel = all-ones counts every cycle.
  - sel 0 or any other value counts nothing.
- Level mode: +1 on each cycle the selected event is high.
- Edge mode: +1 only when the event is high now and was low the previous cycle.
  - The history register (prev = events) updates every cycle, including during freeze.
  - Cycle source in edge mode: counts every cycle.
- freeze high: all increments are suppressed. Register writes and reads still operate.
- Write vs increment in the same cycle on the same counter: the write wins, and that cycle's increment is dropped.
  - Writing reg 0 or reg 1 leaves the other half unchanged.
- Config write: takes effect for the event sampled in the next cycle.
- Wrap: an increment from all-ones sets the counter to 0 and sets sticky ovf in the same edge.
  - Overflow and a status write-1-clear in the same cycle: the set wins.
- ovf_irq: registered; equals OR over i of (ovf[i] & irq_en[i]), one cycle after the flag or enable changes.
- Read latency is 1:
  - A read with csr_re at cycle t gives csr_rvalid=1 and csr_rdata at t+1.
  - csr_rdata holds its value after that. csr_rvalid is 0 otherwise.
  - A read returns the counter value before any same-cycle increment or write.
- 64-bit reads are not atomic; software reads high, low, high.
- csr_we and csr_re in the same cycle are both honoured. The read returns the pre-write value.
- Reset mid-operation: all state clears on that edge, and any pending read response is discarded (csr_rvalid=0).

Test Plan:
- Reset, then read reg 0/1/2/3 of counter 0 -> csr_rvalid pulses one cycle after each csr_re, csr_rdata=0 each time; ovf_irq=0.
- Counter 1 sel=1 (load), level mode; drive events[0] high 5 cycles, low 3, high 2 -> counter 1 reads 7; counter 0 (sel 0) reads 0.
- Counter 2 sel=10 (execute), edge mode; events[9] pattern 1,1,0,1,0,1,1 -> count 3. Repeat with freeze high during the third pulse -> count 2.
- Counter 3 sel=all-ones, irq_en=1, written to 0xFFFFFFFF_FFFFFFFE -> after 2 cycles count=0, ovf=1, ovf_irq=1 one cycle later.
  - Write status 1 -> ovf=0, and ovf_irq=0 one cycle later.
  - Same-cycle wrap and clear -> ovf stays 1.
- Same-cycle write 0x100 to reg 0 while the selected event is high -> reads 0x100 (increment dropped), 0x101 after one more event cycle.
- Access with index = N_COUNTERS (when N_COUNTERS < 2^(ADDR_W-2)) -> write ignored, read 0. Assert rst low mid-count -> all counters 0, csr_rvalid=0.
